cu_mem_arbiter: RTL

- Arbitrates the single MMU/SRAM access port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Latches the winning request and issues a one-cycle start to the MMU.
- Waits for completion with a timeout watchdog, then returns read data and a done pulse to the owning stage.
- Sits in the CU between the pipeline stages and the MMU.

---
 rtl/cu_mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cu_mem_arbiter.sv
// Arbitrates the single MMU/SRAM port between IF (fetch) and MEM (load/store).
// Define ARB_ROUND_ROBIN_EN to alternate owners on contention; default is fixed MEM priority.
module cu_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              soc_clk,
    input  logic              soc_reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_be,
    input  logic              mem_we,
    output logic              mem_gnt,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mmu_start,
    output logic [ADDR_W-1:0] mmu_addr,
    output logic [DATA_W-1:0] mmu_wdata,
    output logic [3:0]        mmu_be,
    output logic              mmu_we,
    input  logic [DATA_W-1:0] mmu_rdata,
    input  logic              mmu_done,
    output logic              arb_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_mem_q, owner_mem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_mem;
    logic              if_gnt_d, mem_gnt_d, mmu_start_d;
    logic              if_done_d, mem_done_d, arb_err_d;
    logic [DATA_W-1:0] if_rdata_d, mem_rdata_d, mmu_wdata_d;
    logic [ADDR_W-1:0] mmu_addr_d;
    logic [3:0]        mmu_be_d;
    logic              mmu_we_d;

`ifdef ARB_ROUND_ROBIN_EN
    // Last-owner resets to IF so MEM wins the first contended grant.
    logic last_mem_q, last_mem_d;
    assign sel_mem = mem_req & (~if_req | ~last_mem_q);
`else
    assign sel_mem = mem_req;
`endif

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        cnt_d       = cnt_q;
        if_gnt_d    = 1'b0;
        mem_gnt_d   = 1'b0;
        mmu_start_d = 1'b0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        arb_err_d   = arb_err;
        if_rdata_d  = if_rdata;
        mem_rdata_d = mem_rdata;
        mmu_addr_d  = mmu_addr;
        mmu_wdata_d = mmu_wdata;
        mmu_be_d    = mmu_be;
        mmu_we_d    = mmu_we;
`ifdef ARB_ROUND_ROBIN_EN
        last_mem_d  = last_mem_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    state_d     = ISSUE;
                    owner_mem_d = sel_mem;
                    mmu_start_d = 1'b1;
                    if (sel_mem) begin
                        mem_gnt_d   = 1'b1;
                        mmu_addr_d  = mem_addr;
                        mmu_wdata_d = mem_wdata;
                        mmu_be_d    = mem_be;
                        mmu_we_d    = mem_we;
                    end else begin
                        if_gnt_d    = 1'b1;
                        mmu_addr_d  = if_addr;
                        mmu_wdata_d = '0;
                        mmu_be_d    = 4'hF;
                        mmu_we_d    = 1'b0;
                    end
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (mmu_done) begin
                    state_d = RESP;
                    if (owner_mem_q) begin
                        mem_rdata_d = mmu_rdata;
                        mem_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = mmu_rdata;
                        if_done_d  = 1'b1;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mmu_done || cnt_q == CNT_LAST) begin
                    // A late mmu_done in the final WAIT cycle still wins over the timeout.
                    state_d = RESP;
                    if (!mmu_done)
                        arb_err_d = 1'b1;
                    if (owner_mem_q) begin
                        mem_rdata_d = mmu_done ? mmu_rdata : '0;
                        mem_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = mmu_done ? mmu_rdata : '0;
                        if_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                last_mem_d = owner_mem_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge soc_clk or negedge soc_reset_n) begin
        if (!soc_reset_n) begin
            state_q     <= IDLE;
            owner_mem_q <= 1'b0;
            cnt_q       <= '0;
            if_gnt      <= 1'b0;
            mem_gnt     <= 1'b0;
            mmu_start   <= 1'b0;
            if_done     <= 1'b0;
            mem_done    <= 1'b0;
            arb_err     <= 1'b0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            mmu_addr    <= '0;
            mmu_wdata   <= '0;
            mmu_be      <= '0;
            mmu_we      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_mem_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            cnt_q       <= cnt_d;
            if_gnt      <= if_gnt_d;
            mem_gnt     <= mem_gnt_d;
            mmu_start   <= mmu_start_d;
            if_done     <= if_done_d;
            mem_done    <= mem_done_d;
            arb_err     <= arb_err_d;
            if_rdata    <= if_rdata_d;
            mem_rdata   <= mem_rdata_d;
            mmu_addr    <= mmu_addr_d;
            mmu_wdata   <= mmu_wdata_d;
            mmu_be      <= mmu_be_d;
            mmu_we      <= mmu_we_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_mem_q  <= last_mem_d;
`endif
        end
    end

endmodule
